// File: rtl/mega_alu_mbseq.sv
// Multi-byte sequencer in front of the 8-bit MEGA ALU: issues one carry-chained ALU op per
// cycle, LSB first, writes each result byte back and accumulates a multi-byte Z flag.
module mega_alu_mbseq #(
  parameter int unsigned MAX_BYTES = 8,
  parameter int unsigned LEN_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [LEN_W-1:0] req_len,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rr,
  input  logic [7:0]       req_sreg,
  output logic [15:0]      alu_inst,
  output logic [4:0]       alu_rda,
  output logic [4:0]       alu_rra,
  output logic [7:0]       alu_sreg_in,
  input  logic [7:0]       alu_r,
  input  logic [7:0]       alu_sreg_out,
  output logic             rf_we,
  output logic [4:0]       rf_wa,
  output logic [7:0]       rf_wd,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       sreg_result
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpCp  = 3'd2;
  localparam logic [2:0] OpAnd = 3'd3;
  localparam logic [2:0] OpOr  = 3'd4;
  localparam logic [2:0] OpEor = 3'd5;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [4:0]       rd_q, rd_d;
  logic [4:0]       rr_q, rr_d;
  logic [7:0]       sreg_q, sreg_d;
  logic [7:0]       sreg_result_q, sreg_result_d;
  logic             err_q, err_d;

  logic             accept;
  logic             req_bad;
  logic             first;
  logic             last;
  logic             zacc;
  logic [5:0]       prefix;

  assign accept = req_valid && (state_q == StIdle);
  assign first  = (idx_q == '0);
  assign last   = (idx_q == len_q - LEN_W'(1));

  // Operand ranges must fit in r0..r31 without wrapping.
  assign req_bad = (req_len == '0) || (32'(req_len) > MAX_BYTES) || (req_op > OpEor) ||
                   (32'(req_rd) + 32'(req_len) > 32'd32) ||
                   (32'(req_rr) + 32'(req_len) > 32'd32);

  // Z must cover every byte, including for logic ops whose ALU Z ignores the chain.
  assign zacc = first ? alu_sreg_out[1] : (sreg_q[1] & alu_sreg_out[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      op_q          <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      rd_q          <= '0;
      rr_q          <= '0;
      sreg_q        <= '0;
      sreg_result_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      rd_q          <= rd_d;
      rr_q          <= rr_d;
      sreg_q        <= sreg_d;
      sreg_result_q <= sreg_result_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    len_d         = len_q;
    idx_d         = idx_q;
    rd_d          = rd_q;
    rr_d          = rr_q;
    sreg_d        = sreg_q;
    sreg_result_d = sreg_result_q;
    err_d         = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            op_d    = req_op;
            len_d   = req_len;
            rd_d    = req_rd;
            rr_d    = req_rr;
            idx_d   = '0;
            sreg_d  = req_sreg;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        sreg_d = {alu_sreg_out[7:2], zacc, alu_sreg_out[0]};
        if (last) begin
          sreg_result_d = sreg_d;
          state_d       = StDone;
        end else begin
          idx_d = idx_q + LEN_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == StIdle);
    busy        = (state_q == StRun);
    done        = (state_q == StDone);
    alu_inst    = '0;
    alu_rda     = '0;
    alu_rra     = '0;
    alu_sreg_in = '0;
    rf_we       = 1'b0;
    rf_wa       = '0;
    rf_wd       = '0;
    prefix      = '0;
    if (state_q == StRun) begin
      alu_rda = rd_q + 5'(idx_q);
      alu_rra = rr_q + 5'(idx_q);
      case (op_q)
        OpAdd:   prefix = first ? 6'b000011 : 6'b000111;
        OpSub:   prefix = first ? 6'b000110 : 6'b000010;
        OpCp:    prefix = first ? 6'b000101 : 6'b000001;
        OpAnd:   prefix = 6'b001000;
        OpOr:    prefix = 6'b001010;
        OpEor:   prefix = 6'b001001;
        default: prefix = '0;
      endcase
      alu_inst    = {prefix, alu_rra[4], alu_rda[4], alu_rda[3:0], alu_rra[3:0]};
      alu_sreg_in = sreg_q;
      rf_we       = (op_q != OpCp);
      rf_wa       = alu_rda;
      rf_wd       = alu_r;
    end
  end

  assign err         = err_q;
  assign sreg_result = sreg_result_q;

endmodule

// File: tb/tb_mega_alu_mbseq.sv
// Bench for mega_alu_mbseq: byte-wise ALU and register-file models around the DUT, checked
// against a full-width integer reference of the multi-byte operation.
module tb_mega_alu_mbseq;

  localparam int unsigned MaxBytes = 8;
  localparam int unsigned LenW     = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [LenW-1:0] req_len;
  logic [4:0]      req_rd;
  logic [4:0]      req_rr;
  logic [7:0]      req_sreg;
  logic [15:0]     alu_inst;
  logic [4:0]      alu_rda;
  logic [4:0]      alu_rra;
  logic [7:0]      alu_sreg_in;
  logic [7:0]      alu_r;
  logic [7:0]      alu_sreg_out;
  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [7:0]      rf_wd;
  logic            busy;
  logic            done;
  logic            err;
  logic [7:0]      sreg_result;

  mega_alu_mbseq #(.MAX_BYTES(MaxBytes), .LEN_W(LenW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_len(req_len), .req_rd(req_rd), .req_rr(req_rr), .req_sreg(req_sreg),
    .alu_inst(alu_inst), .alu_rda(alu_rda), .alu_rra(alu_rra), .alu_sreg_in(alu_sreg_in),
    .alu_r(alu_r), .alu_sreg_out(alu_sreg_out), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .busy(busy), .done(done), .err(err), .sreg_result(sreg_result)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Register file: bulk load from img, otherwise written by the DUT.
  logic [7:0]  rf [32];
  logic [7:0]  img [32];
  logic [7:0]  exp_img [32];
  logic        ld_all;
  int unsigned wr_cnt = 0;

  always @(posedge clk) begin
    if (ld_all) begin
      for (int i = 0; i < 32; i++) rf[i] <= img[i];
    end else if (rf_we) begin
      rf[rf_wa] <= rf_wd;
      wr_cnt    <= wr_cnt + 1;
    end
  end

  // 8-bit AVR ALU decoding the issued opcode.
  logic [5:0] a_pre;
  logic [4:0] a_d, a_r;
  logic [7:0] a_a, a_b, a_res, a_hx;
  logic [8:0] a_s;
  logic       a_c, a_h, a_v, a_n, a_z, a_sf, a_chain;

  always_comb begin
    a_pre   = alu_inst[15:10];
    a_d     = {alu_inst[8], alu_inst[7:4]};
    a_r     = {alu_inst[9], alu_inst[3:0]};
    a_a     = rf[a_d];
    a_b     = rf[a_r];
    a_s     = '0;
    a_res   = '0;
    a_hx    = '0;
    a_chain = 1'b0;
    a_c     = alu_sreg_in[0];
    a_z     = alu_sreg_in[1];
    a_n     = alu_sreg_in[2];
    a_v     = alu_sreg_in[3];
    a_sf    = alu_sreg_in[4];
    a_h     = alu_sreg_in[5];
    case (a_pre)
      6'b000011, 6'b000111: begin
        a_chain = (a_pre == 6'b000111);
        a_s     = {1'b0, a_a} + {1'b0, a_b} + {8'h00, a_chain & alu_sreg_in[0]};
        a_res   = a_s[7:0];
        a_hx    = a_a ^ a_b ^ a_res;
        a_c     = a_s[8];
        a_h     = a_hx[4];
        a_v     = (a_a[7] == a_b[7]) && (a_res[7] != a_a[7]);
        a_z     = (a_res == 8'h00);
        a_n     = a_res[7];
        a_sf    = a_n ^ a_v;
      end
      6'b000110, 6'b000101, 6'b000010, 6'b000001: begin
        a_chain = (a_pre == 6'b000010) || (a_pre == 6'b000001);
        a_s     = {1'b0, a_a} - {1'b0, a_b} - {8'h00, a_chain & alu_sreg_in[0]};
        a_res   = a_s[7:0];
        a_hx    = a_a ^ a_b ^ a_res;
        a_c     = a_s[8];
        a_h     = a_hx[4];
        a_v     = (a_a[7] != a_b[7]) && (a_res[7] != a_a[7]);
        a_z     = (a_res == 8'h00) && (!a_chain || alu_sreg_in[1]);
        a_n     = a_res[7];
        a_sf    = a_n ^ a_v;
      end
      6'b001000, 6'b001010, 6'b001001: begin
        if (a_pre == 6'b001000)      a_res = a_a & a_b;
        else if (a_pre == 6'b001010) a_res = a_a | a_b;
        else                         a_res = a_a ^ a_b;
        a_v  = 1'b0;
        a_z  = (a_res == 8'h00);
        a_n  = a_res[7];
        a_sf = a_n;
      end
      default: ;
    endcase
    alu_r        = a_res;
    alu_sreg_out = {alu_sreg_in[7:6], a_h, a_sf, a_v, a_n, a_z, a_c};
  end

  // Whole-operand reference: returns {sreg, result}.
  function automatic logic [71:0] ref_model(input int op, input int len, input logic [63:0] a,
                                            input logic [63:0] b, input logic [7:0] sin);
    logic [71:0] wa, wb, full, hx, mask, r;
    logic        c, h, v, n, z;
    int          nb;
    nb   = 8 * len;
    mask = (72'd1 << nb) - 72'd1;
    wa   = {8'h00, a} & mask;
    wb   = {8'h00, b} & mask;
    case (op)
      0:       full = wa + wb;
      1, 2:    full = wa - wb;
      3:       full = wa & wb;
      4:       full = wa | wb;
      default: full = wa ^ wb;
    endcase
    r  = full & mask;
    hx = wa ^ wb ^ full;
    n  = r[nb-1];
    z  = (r == 72'd0);
    if (op <= 2) begin
      c = full[nb];
      h = hx[nb-4];
      if (op == 0) v = (wa[nb-1] == wb[nb-1]) && (n != wa[nb-1]);
      else         v = (wa[nb-1] != wb[nb-1]) && (n != wa[nb-1]);
    end else begin
      c = sin[0];
      h = sin[5];
      v = 1'b0;
    end
    return {sin[7:6], h, n ^ v, v, n, z, c, r[63:0]};
  endfunction

  task automatic check(input string tag, input string what, input logic [71:0] got,
                       input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s %s: got %0h, expected %0h", tag, what, got, exp);
    end
  endtask

  task automatic cmp_rf(input string tag);
    int nmis;
    nmis = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== exp_img[i]) nmis++;
    check(tag, "rf_mismatching_regs", nmis, 0);
  endtask

  task automatic load_img();
    @(negedge clk);
    ld_all = 1'b1;
    @(negedge clk);
    ld_all = 1'b0;
  endtask

  task automatic do_op(input string tag, input int op, input int len, input int rd, input int rr,
                       input logic [7:0] sin, input bit exp_err, input logic [7:0] exp_sreg,
                       input logic [63:0] exp_res);
    int          cnt;
    int unsigned w0;
    exp_img = img;
    if (!exp_err && op != 2) for (int i = 0; i < len; i++) exp_img[rd+i] = exp_res[8*i +: 8];
    load_img();
    w0 = wr_cnt;
    @(negedge clk);
    check(tag, "ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_op    = 3'(op);
    req_len   = LenW'(len);
    req_rd    = 5'(rd);
    req_rr    = 5'(rr);
    req_sreg  = sin;
    @(negedge clk);
    req_valid = 1'b0;
    req_rd    = ~req_rd;
    req_rr    = ~req_rr;
    req_sreg  = ~sin;
    if (exp_err) begin
      check(tag, "err", err, 1'b1);
      check(tag, "ready_after_err", req_ready, 1'b1);
      check(tag, "busy_after_err", busy, 1'b0);
      @(negedge clk);
      check(tag, "err_one_cycle", err, 1'b0);
    end else begin
      check(tag, "no_err", err, 1'b0);
      check(tag, "busy", busy, 1'b1);
      cnt = 1;
      while (!done && cnt < 4 * MaxBytes) begin
        @(negedge clk);
        cnt++;
      end
      check(tag, "done_cycle", cnt, len + 1);
      check(tag, "sreg_result", sreg_result, exp_sreg);
      check(tag, "ready_in_done", req_ready, 1'b0);
      @(negedge clk);
      check(tag, "done_one_cycle", done, 1'b0);
      check(tag, "ready_after_done", req_ready, 1'b1);
      check(tag, "sreg_result_held", sreg_result, exp_sreg);
    end
    check(tag, "write_count", wr_cnt - w0, (exp_err || op == 2) ? 0 : len);
    cmp_rf(tag);
    img = exp_img;
  endtask

  task automatic run_model(input string tag, input int op, input int len, input int rd,
                           input int rr, input logic [7:0] sin);
    logic [63:0] a, b;
    logic [71:0] m;
    a = '0;
    b = '0;
    for (int i = 0; i < len; i++) begin
      a[8*i +: 8] = img[rd+i];
      b[8*i +: 8] = img[rr+i];
    end
    m = ref_model(op, len, a, b, sin);
    do_op(tag, op, len, rd, rr, sin, 1'b0, m[71:64], m[63:0]);
  endtask

  typedef struct {
    int          op;
    int          len;
    int          rd;
    int          rr;
    logic [63:0] a;
    logic [63:0] b;
    logic [7:0]  sin;
    bit          exp_err;
    logic [7:0]  exp_sreg;
    logic [63:0] exp_res;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int          w0;
    bit          seen_done;
    logic [7:0]  r24_exp;

    vecs[0]  = '{0, 2, 24, 26, 64'h00FF, 64'h0001, 8'h00, 1'b0, 8'h00, 64'h0100};
    vecs[1]  = '{1, 2, 24, 26, 64'h0100, 64'h0100, 8'h00, 1'b0, 8'h02, 64'h0000};
    vecs[2]  = '{2, 2, 24, 26, 64'h1234, 64'h1235, 8'h00, 1'b0, 8'h35, 64'h1234};
    vecs[3]  = '{4, 4, 24, 26, 64'h0, 64'h0, 8'h01, 1'b0, 8'h03, 64'h0};
    vecs[4]  = '{4, 4, 24, 26, 64'h1, 64'h0, 8'hC1, 1'b0, 8'hC1, 64'h1};
    vecs[5]  = '{3, 1, 0, 31, 64'hF0, 64'h8F, 8'h20, 1'b0, 8'h34, 64'h80};
    vecs[6]  = '{5, 3, 16, 5, 64'hAABBCC, 64'hAABBCC, 8'h00, 1'b0, 8'h02, 64'h0};
    vecs[7]  = '{0, 8, 24, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 8'h00, 1'b0, 8'h23, 64'h0};
    vecs[8]  = '{0, 4, 30, 0, 64'h0, 64'h0, 8'h00, 1'b1, 8'h00, 64'h0};
    vecs[9]  = '{0, 0, 0, 4, 64'h0, 64'h0, 8'h00, 1'b1, 8'h00, 64'h0};
    vecs[10] = '{6, 1, 0, 4, 64'h0, 64'h0, 8'h00, 1'b1, 8'h00, 64'h0};
    vecs[11] = '{1, 4, 0, 29, 64'h0, 64'h0, 8'h00, 1'b1, 8'h00, 64'h0};
    vecs[12] = '{0, 9, 0, 16, 64'h0, 64'h0, 8'h00, 1'b1, 8'h00, 64'h0};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_len   = '0;
    req_rd    = '0;
    req_rr    = '0;
    req_sreg  = '0;
    ld_all    = 1'b0;
    for (int i = 0; i < 32; i++) img[i] = 8'h00;

    @(negedge clk);
    @(negedge clk);
    check("reset", "req_ready", req_ready, 1'b1);
    check("reset", "busy_done_err_we", {busy, done, err, rf_we}, 4'b0000);
    check("reset", "alu_inst", alu_inst, 16'h0000);
    check("reset", "addr_sreg_wdata", {alu_rda, alu_rra, alu_sreg_in, rf_wa, rf_wd}, 31'h0);
    check("reset", "sreg_result", sreg_result, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", "idle_outputs", {req_ready, busy, done, err, rf_we}, 5'b10000);

    for (int v = 0; v < 13; v++) begin
      for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
      if (!vecs[v].exp_err) begin
        for (int i = 0; i < vecs[v].len; i++) begin
          img[vecs[v].rd+i] = vecs[v].a[8*i +: 8];
          img[vecs[v].rr+i] = vecs[v].b[8*i +: 8];
        end
      end
      do_op($sformatf("vec%0d", v), vecs[v].op, vecs[v].len, vecs[v].rd, vecs[v].rr,
            vecs[v].sin, vecs[v].exp_err, vecs[v].exp_sreg, vecs[v].exp_res);
    end

    // Reset in the middle of a 4-byte ADD, once byte 0 has been written.
    for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
    exp_img = img;
    r24_exp = img[24] + img[26];
    exp_img[24] = r24_exp;
    load_img();
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_len   = LenW'(4);
    req_rd    = 5'd24;
    req_rr    = 5'd26;
    req_sreg  = 8'h00;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset", "busy", busy, 1'b0);
    check("midreset", "rf_we", rf_we, 1'b0);
    check("midreset", "req_ready", req_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("midreset", "no_done", seen_done, 1'b0);
    check("midreset", "write_count", wr_cnt - w0, 1);
    cmp_rf("midreset");
    img = exp_img;
    run_model("after_reset", 0, 4, 24, 26, 8'h00);

    for (int t = 0; t < 60; t++) begin
      int op, len, rd, rr;
      op  = int'($urandom_range(0, 5));
      len = int'($urandom_range(1, MaxBytes));
      rd  = int'($urandom_range(0, 32 - len));
      // Keep rr out of the window where byte-serial reads see earlier result bytes.
      do rr = int'($urandom_range(0, 32 - len)); while (rr < rd && rr > rd - len);
      for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
      run_model($sformatf("rand%0d", t), op, len, rd, rr, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
